// File: rtl/fir_framer_pkg.sv
// Shared helpers for fir_framer: accumulator sizing, output bounds and round/saturate.
package fir_framer_pkg;

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Round half up, arithmetic shift, clamp; frac must be >= 1 and acc must fit 64 bits.
    function automatic longint round_sat(input longint acc, input int unsigned frac,
                                         input longint lo, input longint hi);
        longint r;
        r = (acc + (longint'(1) <<< (frac - 1))) >>> frac;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_frame_counter.sv
// Wrapping output-sample counter that marks the first and last sample of each frame.
module fir_frame_counter
    import fir_framer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic valid,
    output logic frame_start,
    output logic frame_end
);

    localparam int unsigned CntW = $clog2(FRAME_LEN);
    localparam logic [CntW-1:0] Last = CntW'(FRAME_LEN - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (valid) begin
            count_q <= (count_q == Last) ? '0 : count_q + 1'b1;
        end
    end

    assign frame_start = valid && (count_q == '0);
    assign frame_end   = valid && (count_q == Last);

endmodule

// File: rtl/fir_framer.sv
// Streaming FIR front-end: loadable coefficients, bypass, fill gating and frame strobes.
module fir_framer
    import fir_framer_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned TAPS      = 32,
    parameter int unsigned FRAC      = 15,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     bypass,
    input  logic                     flush,
    input  logic                     data_valid,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] fir_d,
    output logic                     fir_valid,
    output logic                     frame_start,
    output logic                     frame_end
);

    localparam int unsigned AddrW = $clog2(TAPS);
    localparam int unsigned ProdW = DATA_W + COEF_W;
    localparam int unsigned AccW  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int unsigned FillW = $clog2(TAPS + 1);
    localparam longint      SatHi = sat_max(DATA_W);
    localparam longint      SatLo = sat_min(DATA_W);

    logic signed [DATA_W-1:0] taps_q [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic                     coef_we_q;
    logic [AddrW-1:0]         coef_addr_q;
    logic signed [COEF_W-1:0] coef_data_q;
    logic [FillW-1:0]         fill_q;
    logic                     s0_valid_q, s0_byp_q;
    logic signed [ProdW-1:0]  prod_q [TAPS];
    logic                     s1_valid_q, s1_byp_q;
    logic signed [DATA_W-1:0] s1_data_q;
    logic signed [AccW-1:0]   acc_sum;
    logic                     accept, fill_done;

    assign accept    = data_valid && !flush;
    assign fill_done = fill_q >= FillW'(TAPS - 1);

    // Writes commit one edge late so a sample accepted alongside a write still sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else begin
            coef_we_q   <= coef_we;
            coef_addr_q <= coef_addr;
            coef_data_q <= coef_data;
            if (coef_we_q) coef_q[coef_addr_q] <= coef_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q     <= '0;
            s0_valid_q <= 1'b0;
            s0_byp_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
        end else if (flush) begin
            fill_q     <= '0;
            s0_valid_q <= 1'b0;
            s0_byp_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
        end else begin
            s0_valid_q <= accept && (bypass || fill_done);
            if (accept) begin
                s0_byp_q  <= bypass;
                taps_q[0] <= data;
                for (int i = TAPS - 1; i > 0; i--) taps_q[i] <= taps_q[i-1];
                if (fill_q != FillW'(TAPS)) fill_q <= fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_byp_q  <= s0_byp_q;
                s1_data_q <= taps_q[0];
                for (int i = 0; i < TAPS; i++) begin
                    prod_q[i] <= ProdW'(taps_q[i]) * ProdW'(coef_q[i]);
                end
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < TAPS; i++) acc_sum = acc_sum + AccW'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fir_valid <= 1'b0;
            fir_d     <= '0;
        end else if (flush) begin
            fir_valid <= 1'b0;
            fir_d     <= '0;
        end else begin
            fir_valid <= s1_valid_q;
            if (s1_valid_q) begin
                fir_d <= s1_byp_q ? s1_data_q
                                  : DATA_W'(round_sat(longint'(acc_sum), FRAC, SatLo, SatHi));
            end
        end
    end

    fir_frame_counter #(
        .FRAME_LEN(FRAME_LEN)
    ) u_frame_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .valid      (fir_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end)
    );

endmodule

// File: doc/fir_framer.md
Name: fir_framer

Overview:
- Parametrised streaming FIR front-end, the successor to the fixed FIR stage inside FAS.
- Filters a signed sample stream using run-time-loadable coefficients and an optional bypass mode.
- Marks output frames of FRAME_LEN samples with start/end strobes, so a downstream FFT of any size can consume blocks directly.
- Sits between the sample source (data_valid/data) and the FFT/peak-detect stage.

Parameters:
- DATA_W, 16, signed input/output sample width
- COEF_W, 16, signed coefficient width
- TAPS, 32, filter length (>=2)
- FRAC, 15, coefficient fractional bits; output = round(sum >> FRAC)
- FRAME_LEN, 16, output samples per frame (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index; 0 multiplies the newest sample
- coef_data  in  COEF_W  signed coefficient value
- bypass  in  1  1 = pass input straight through (no filtering)
- flush  in  1  synchronous clear of delay line and counters
- data_valid  in  1  input sample qualifier
- data  in  DATA_W  signed input sample
- fir_d  out  DATA_W  filtered sample
- fir_valid  out  1  fir_d qualifier, one cycle per output
- frame_start  out  1  high with the first fir_valid of each frame
- frame_end  out  1  high with the FRAME_LEN-th fir_valid of each frame

Behaviour:
- Reset (rst=0, async): delay line, coefficients, fill and frame counters, pipeline registers and all outputs go to 0.
- Input acceptance: every cycle with data_valid=1 shifts data into the TAPS-deep delay line; there is no backpressure.
- Pipeline:
  - Stage 1 registers the TAPS products (DATA_W+COEF_W bits each).
  - Stage 2 adds the products in an accumulator of DATA_W+COEF_W+$clog2(TAPS) bits, rounds, saturates and registers the result.
  - Latency is fixed at 2 cycles from the accepted sample edge to fir_valid.
- Rounding: add 1<<(FRAC-1), arithmetic shift right by FRAC, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Fill:
  - fir_valid is suppressed until TAPS samples have been accepted since reset or flush.
  - The first output corresponds to the TAPS-th sample.
  - The fill counter saturates at TAPS.
- Bypass:
  - With bypass=1 at acceptance, fir_d = data, with the same 2-cycle latency.
  - fir_valid follows data_valid immediately, ignoring fill.
  - The delay line keeps shifting, so switching back to bypass=0 needs no refill if TAPS samples were seen.
- Coefficient write:
  - coef_we writes coef_data at coef_addr on the clock edge.
  - The new value applies to samples accepted from the next cycle onward.
  - A write in the same cycle as an accepted sample is not used for that sample.
  - Writes are legal at any time; coefficients survive flush.
- Frames:
  - A frame counter (0..FRAME_LEN-1) advances on each fir_valid output.
  - frame_start = fir_valid & (count==0); frame_end = fir_valid & (count==FRAME_LEN-1).
  - The counter wraps to 0 after frame_end.
- Flush:
  - Clears the delay line, fill counter, frame counter and both pipeline stages.
  - Outputs in flight are discarded: fir_valid=0 on the next two cycles.
  - Flush has priority over a simultaneous data_valid, whose sample is dropped.
- Gaps: data_valid low produces no output and does not advance the counters; the pipeline holds its state.
- Reset during operation discards everything, including coefficients.

Decomposition:
- Package fir_framer_pkg holds:
  - the accumulator-width function;
  - the saturation bounds as localparams derived from DATA_W;
  - the round-and-saturate function.
- One sub-module, fir_frame_counter, holds the wrapping counter plus the start/end strobe logic, with FRAME_LEN as its parameter.
- The MAC stays inline.

Test Plan:
- Identity: coef[0]=16'h4000, others 0 (TAPS=32, FRAC=15); stream 32 samples of 1000 -> first fir_valid 2 cycles after the 32nd sample, fir_d=500; no fir_valid before that.
- Moving sum with saturation: all 32 coefs=16'h7FFF; inputs 32767 -> fir_d saturates at 32767; inputs -32768 -> fir_d=-32768.
- Framing: identity coefs, continuous input of 80 samples -> 49 outputs; frame_start on outputs 1, 17, 33, 49; frame_end on outputs 16, 32, 48.
- Bypass/gaps: bypass=1, alternating data_valid, data=-7 -> fir_d=-7 exactly 2 cycles after each accepted sample; no output on idle cycles.
- Flush/coef-write race:
  - Coefficient write coincides with an accepted sample -> that sample uses the old coefficient, the next uses the new one.
  - Flush with data_valid=1 after 40 samples -> two outputs dropped, then no fir_valid until 32 new samples, frame count restarts at frame_start.
- Async reset: drop rst mid-frame between clock edges -> outputs 0 immediately; after release, identity output requires the coefficient reload and a full refill.
